// File: rtl/init_ram.sv
// Single-port synchronous RAM with a built-in sequencer that fills the first INIT_COUNT entries.
// Reads have one cycle of latency. Accesses made while the sequencer runs are dropped and flagged.
module init_ram #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 5,
    parameter int                INIT_COUNT = 16,
    parameter int                INIT_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              init_start,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              init_done,
    output logic              req_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    // The pointer is one bit wider than the address so a full-depth init can end without wrapping.
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(INIT_COUNT - 1);

    typedef enum logic {IDLE, INIT} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ident, pattern;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat;

    generate
        if (DATA_W > PW) begin : g_ident_ext
            assign ident = {{(DATA_W - PW){1'b0}}, ptr};
        end else if (DATA_W == PW) begin : g_ident_eq
            assign ident = ptr;
        end else begin : g_ident_trunc
            assign ident = ptr[DATA_W-1:0];
        end
    endgenerate

    assign pattern = (INIT_MODE == 1) ? INIT_VALUE : ident;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (init_start) begin
                    state_nxt = INIT;
                    ptr_nxt   = '0;
                end
            end
            INIT: begin
                ptr_nxt = ptr + PW'(1);
                if (ptr == LAST_PTR) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign busy     = (state == INIT);
    assign mem_we   = busy | we;
    assign mem_addr = busy ? ptr[ADDR_W-1:0] : addr;
    assign mem_wdat = busy ? pattern : d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            init_done <= 1'b0;
            req_drop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            q_valid   <= !busy && re;
            init_done <= busy && (state_nxt == IDLE);
            req_drop  <= busy && (we || re);
            if (!busy && re) begin
                q <= mem[addr];
            end
        end
    end

    // The array has no reset; a same-cycle read sees the old word because q samples before this write lands.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
    end
endmodule

// File: tb/tb_init_ram.sv
// Bench for init_ram: directed scenarios plus random traffic against a transaction-level memory model.
module tb_init_ram;
    logic       clock;
    logic       resetn;
    logic       init_start, we, re;
    logic [4:0] addr;
    logic [7:0] d, q;
    logic       q_valid, busy, init_done, req_drop;

    logic       init_start2, we2, re2;
    logic [4:0] addr2;
    logic [7:0] d2, q2;
    logic       q_valid2, busy2, init_done2, req_drop2;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: memory contents, which entries are defined, and remaining init cycles.
    logic [7:0] mm [32];
    bit         known [32];
    int         busy_left = 0;
    int         init_idx  = 0;
    logic [7:0] exp_q     = 8'h00;
    bit         q_known   = 1'b1;
    bit         exp_qv, exp_done, exp_drop;

    init_ram dut (
        .clock(clock), .resetn(resetn), .init_start(init_start), .we(we), .re(re),
        .addr(addr), .d(d), .q(q), .q_valid(q_valid), .busy(busy),
        .init_done(init_done), .req_drop(req_drop)
    );

    init_ram #(.DATA_W(8), .ADDR_W(5), .INIT_COUNT(32), .INIT_MODE(1), .INIT_VALUE(8'hA5)) dut2 (
        .clock(clock), .resetn(resetn), .init_start(init_start2), .we(we2), .re(re2),
        .addr(addr2), .d(d2), .q(q2), .q_valid(q_valid2), .busy(busy2),
        .init_done(init_done2), .req_drop(req_drop2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check1(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of dut: apply inputs, advance the model, then compare every output after the edge.
    task automatic step(bit st, bit w, bit r, int a, logic [7:0] dd);
        init_start = st;
        we         = w;
        re         = r;
        addr       = a[4:0];
        d          = dd;
        exp_drop   = (busy_left > 0) && (w || r);
        exp_done   = 1'b0;
        exp_qv     = 1'b0;
        if (busy_left > 0) begin
            mm[init_idx]    = init_idx[7:0];
            known[init_idx] = 1'b1;
            init_idx++;
            busy_left--;
            exp_done = (busy_left == 0);
        end else begin
            if (r) begin
                exp_q   = mm[a];
                q_known = known[a];
                exp_qv  = 1'b1;
            end
            if (w) begin
                mm[a]    = dd;
                known[a] = 1'b1;
            end
            if (st) begin
                busy_left = 16;
                init_idx  = 0;
            end
        end
        @(posedge clock);
        #1;
        init_start = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        check1("busy", busy, busy_left > 0);
        check1("init_done", init_done, exp_done);
        check1("req_drop", req_drop, exp_drop);
        check1("q_valid", q_valid, exp_qv);
        if (q_known) check8("q", q, exp_q);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        busy_left = 0;
        exp_q     = 8'h00;
        q_known   = 1'b1;
        #2;
        check1("rst_busy", busy, 1'b0);
        check1("rst_q_valid", q_valid, 1'b0);
        check1("rst_init_done", init_done, 1'b0);
        check1("rst_req_drop", req_drop, 1'b0);
        check8("rst_q", q, 8'h00);
        check1("rst_busy2", busy2, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && busy_left > 0; g++) step(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        int bc, dc, guard;
        for (int i = 0; i < 32; i++) begin
            mm[i]    = 8'h00;
            known[i] = 1'b0;
        end
        resetn = 1'b1;
        {init_start, we, re, addr, d} = '0;
        {init_start2, we2, re2, addr2, d2} = '0;
        #1;
        do_reset();

        // Default init: identity pattern over 16 entries, then read them back.
        step(1, 0, 0, 0, 8'h00);
        drain();
        for (int i = 0; i < 16; i++) step(0, 0, 1, i, 8'h00);

        // Accesses during init are dropped; q must hold its value.
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 3, 8'hFF);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 5, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        drain();
        step(0, 0, 1, 3, 8'h00);
        check8("mem3_after_init", q, 8'h03);

        // Read-before-write on a simultaneous access.
        step(0, 1, 0, 7, 8'h5A);
        step(0, 1, 1, 7, 8'h3C);
        check8("rbw_old", q, 8'h5A);
        step(0, 0, 1, 7, 8'h00);
        check8("rbw_new", q, 8'h3C);

        // Abort init with reset after 5 writes; untouched entries keep prior contents.
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'h00);
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 1, i, 8'h00);
        step(0, 0, 1, 7, 8'h00);
        check8("abort_keeps_7", q, 8'h3C);
        step(1, 0, 0, 0, 8'h00);
        drain();

        // Constant-fill, full-depth instance: exactly 32 busy cycles and one done pulse.
        init_start2 = 1'b1;
        @(posedge clock);
        #1;
        init_start2 = 1'b0;
        bc = 0;
        dc = 0;
        guard = 0;
        while (busy2 && guard < 100) begin
            bc++;
            guard++;
            @(posedge clock);
            #1;
            if (init_done2) dc++;
        end
        check8("fill_busy_cycles", 8'(bc), 8'd32);
        check8("fill_done_pulses", 8'(dc), 8'd1);
        check1("fill_busy_end", busy2, 1'b0);
        re2   = 1'b1;
        addr2 = 5'd0;
        @(posedge clock);
        #1;
        check1("fill_qv0", q_valid2, 1'b1);
        check8("fill_q0", q2, 8'hA5);
        addr2 = 5'd31;
        @(posedge clock);
        #1;
        re2 = 1'b0;
        check1("fill_qv31", q_valid2, 1'b1);
        check8("fill_q31", q2, 8'hA5);

        // Random traffic, including init_start while busy.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), 8'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
